// File: rtl/jrb8_bus_pkg.sv
// Shared definitions for the memory bus arbiter.
// Holds the FSM state encoding, the grant encoding, the default bus widths
// and the read value returned when a memory access is aborted.
package jrb8_bus_pkg;

    localparam int AW_DEF = 16;
    localparam int DW_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        FETCH = 1'b0,
        DATA  = 1'b1
    } grant_t;

    // Read data handed back when an access times out.
    localparam logic [7:0] ABORT_RDATA = 8'hFF;

endpackage

// File: rtl/bus_timeout_timer.sv
// Saturating WAIT-cycle counter for the bus arbiter.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : return the count to zero (lower priority than enable)
//   enable     : count one cycle, saturating at TIMEOUT
//   expired    : high while the count equals TIMEOUT
// TIMEOUT = 0 removes the counter and ties expired low.
module bus_timeout_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    generate
        if (TIMEOUT == 0) begin : g_off
            assign expired = 1'b0;
        end else begin : g_cnt
            localparam int CW = $clog2(TIMEOUT + 1);
            localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

            logic [CW-1:0] count;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    count <= '0;
                end else if (enable) begin
                    if (count != LIMIT) count <= count + 1'b1;
                end else if (clear) begin
                    count <= '0;
                end
            end

            assign expired = (count == LIMIT);
        end
    endgenerate

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single external memory port between instruction fetch and
// data load/store, runs the req/ack handshake with a variable-latency memory
// controller, and returns read data plus a one-cycle done pulse.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   f_req/f_addr               : fetch request (level) and address
//   f_done/f_rdata             : fetch completion pulse and held read byte
//   d_req/d_we/d_addr/d_wdata  : data request, store flag, address, store data
//   d_done/d_rdata             : data completion pulse and held load result
//   mem_req/we/addr/wdata      : registered request to the memory controller
//   mem_rdata/mem_ack          : memory read data and completion pulse
//   stall                      : hold the control unit while a request is open
//   err/err_clr                : sticky timeout flag and its clear
module mem_bus_arbiter
    import jrb8_bus_pkg::*;
#(
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_done,
    output logic [DW-1:0] f_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_done,
    output logic [DW-1:0] d_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          stall,
    output logic          err,
    input  logic          err_clr
);

    state_t state;
    grant_t grant, last_grant, win;
    logic   start, expired, timeout;

    // Winner selection: a lone requester wins; a tie goes to whoever was
    // not served last.
    always_comb begin
        start = (state == IDLE) && (f_req || d_req);
        if (f_req && d_req) win = (last_grant == DATA) ? FETCH : DATA;
        else if (f_req)     win = FETCH;
        else                win = DATA;
    end

    // A same-edge ack beats the timeout.
    assign timeout = (state == WAIT) && !mem_ack && expired;

    // Enabled on the grant edge too, so the count equals the number of the
    // current WAIT cycle and mem_req stays up for exactly TIMEOUT cycles.
    bus_timeout_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state != WAIT),
        .enable (start || (state == WAIT)),
        .expired(expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant      <= FETCH;
            last_grant <= DATA;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            f_rdata    <= '0;
            d_rdata    <= '0;
            f_done     <= 1'b0;
            d_done     <= 1'b0;
            err        <= 1'b0;
        end else begin
            f_done <= 1'b0;
            d_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        grant      <= win;
                        last_grant <= win;
                        mem_req    <= 1'b1;
                        mem_we     <= (win == DATA) && d_we;
                        mem_addr   <= (win == DATA) ? d_addr : f_addr;
                        mem_wdata  <= (win == DATA) ? d_wdata : '0;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_ack || timeout) begin
                        mem_req <= 1'b0;
                        if (!mem_we) begin
                            if (grant == FETCH) f_rdata <= mem_ack ? mem_rdata : DW'(ABORT_RDATA);
                            else                d_rdata <= mem_ack ? mem_rdata : DW'(ABORT_RDATA);
                        end
                        if (grant == FETCH) f_done <= 1'b1;
                        else                d_done <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase

            if (timeout)      err <= 1'b1;
            else if (err_clr) err <= 1'b0;
        end
    end

    assign stall = (f_req & ~f_done) | (d_req & ~d_done);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with TIMEOUT = 4.
module tb_mem_bus_arbiter;

    logic        clk, rst_n;
    logic        f_req, f_done;
    logic [15:0] f_addr;
    logic [7:0]  f_rdata;
    logic        d_req, d_we, d_done;
    logic [15:0] d_addr;
    logic [7:0]  d_wdata, d_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        stall, err, err_clr;

    int n_vec = 0;
    int n_err = 0;

    mem_bus_arbiter #(.AW(16), .DW(8), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .f_req(f_req), .f_addr(f_addr), .f_done(f_done), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall(stall), .err(err), .err_clr(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; f_req = 0; f_addr = 0; d_req = 0; d_we = 0; d_addr = 0;
        d_wdata = 0; mem_ack = 0; mem_rdata = 0; err_clr = 0;
        tick(); tick();
        check("rst_mem_req", mem_req, 0);
        check("rst_f_done", f_done, 0);
        check("rst_d_done", d_done, 0);
        check("rst_rdata", {f_rdata, d_rdata}, 0);
        check("rst_err", err, 0);
        check("rst_stall", stall, 0);
        rst_n = 1'b1;
        tick();

        // Fetch only, ack in third WAIT cycle
        f_req = 1; f_addr = 16'h0010; #1;
        check("f1_stall_req", stall, 1);
        tick();
        check("f1_mem_req_c1", mem_req, 1);
        check("f1_mem_addr", mem_addr, 16'h0010);
        check("f1_mem_we", mem_we, 0);
        tick();
        check("f1_mem_req_c2", mem_req, 1);
        tick();
        check("f1_mem_req_c3", mem_req, 1);
        check("f1_no_done_yet", f_done, 0);
        mem_ack = 1; mem_rdata = 8'hA5;
        tick();
        check("f1_done", f_done, 1);
        check("f1_rdata", f_rdata, 8'hA5);
        check("f1_mem_req_drop", mem_req, 0);
        check("f1_stall_fall", stall, 0);
        mem_ack = 0; f_req = 0;
        tick();
        check("f1_done_pulse", f_done, 0);
        check("f1_rdata_held", f_rdata, 8'hA5);

        // Tie after reset: fetch first, then data, then fetch again
        rst_n = 0; #2; rst_n = 1;
        tick();
        f_req = 1; d_req = 1; d_we = 0; f_addr = 16'h0020; d_addr = 16'h0200;
        tick();
        check("tie1_addr_fetch", mem_addr, 16'h0020);
        mem_ack = 1; mem_rdata = 8'h11;
        tick();
        check("tie1_f_done", f_done, 1);
        check("tie1_d_done", d_done, 0);
        mem_ack = 0; f_req = 0; #1;
        check("tie1_stall_data", stall, 1);
        tick();
        check("tie1_bubble", mem_req, 0);
        tick();
        check("tie2_mem_req", mem_req, 1);
        check("tie2_addr_data", mem_addr, 16'h0200);
        mem_ack = 1; mem_rdata = 8'h22;
        tick();
        check("tie2_d_done", d_done, 1);
        check("tie2_d_rdata", d_rdata, 8'h22);
        check("tie2_f_rdata_held", f_rdata, 8'h11);
        mem_ack = 0; f_req = 1; f_addr = 16'h0030;
        tick();
        tick();
        check("tie3_addr_fetch", mem_addr, 16'h0030);
        mem_ack = 1; mem_rdata = 8'h33;
        tick();
        check("tie3_f_done", f_done, 1);
        mem_ack = 0; f_req = 0; d_req = 0;
        tick();

        // Store with ack in first WAIT cycle
        d_req = 1; d_we = 1; d_addr = 16'h01FF; d_wdata = 8'h3C;
        tick();
        check("st_mem_we", mem_we, 1);
        check("st_mem_wdata", mem_wdata, 8'h3C);
        check("st_mem_addr", mem_addr, 16'h01FF);
        mem_ack = 1; mem_rdata = 8'h99;
        tick();
        check("st_d_done", d_done, 1);
        check("st_d_rdata_kept", d_rdata, 8'h22);
        mem_ack = 0; d_req = 0; d_we = 0;
        tick();

        // Timeout: no ack for 4 WAIT cycles
        f_req = 1; f_addr = 16'h0040;
        tick(); tick(); tick(); tick();
        check("to_mem_req_c4", mem_req, 1);
        check("to_err_before", err, 0);
        tick();
        check("to_mem_req_drop", mem_req, 0);
        check("to_err_set", err, 1);
        check("to_f_rdata", f_rdata, 8'hFF);
        check("to_f_done", f_done, 1);
        f_req = 0;
        tick();
        check("to_err_sticky", err, 1);
        err_clr = 1;
        tick();
        check("to_err_clr", err, 0);
        err_clr = 0;

        // Ack on the timeout edge is a normal completion
        f_req = 1; f_addr = 16'h0050;
        tick(); tick(); tick(); tick();
        mem_ack = 1; mem_rdata = 8'h5A;
        tick();
        check("toack_err", err, 0);
        check("toack_rdata", f_rdata, 8'h5A);
        check("toack_done", f_done, 1);
        mem_ack = 0; f_req = 0;
        tick();

        // Timeout set beats a simultaneous clear
        f_req = 1; err_clr = 1;
        tick(); tick(); tick(); tick(); tick();
        check("toclr_set_wins", err, 1);
        f_req = 0;
        tick();
        check("toclr_cleared", err, 0);
        err_clr = 0;

        // Reset in the middle of WAIT
        d_req = 1; d_addr = 16'h0300;
        tick();
        check("rw_mem_req", mem_req, 1);
        #2; rst_n = 0; #1;
        check("rw_async_drop", mem_req, 0);
        check("rw_rdata_clr", f_rdata, 0);
        d_req = 0; #1; rst_n = 1;
        tick();
        check("rw_stall", stall, 0);
        check("rw_no_done", {f_done, d_done}, 0);
        tick();
        check("rw_idle", mem_req, 0);
        check("rw_no_done2", {f_done, d_done}, 0);

        // Stray ack while idle
        mem_ack = 1; mem_rdata = 8'h77;
        tick();
        check("stray_no_done", {f_done, d_done}, 0);
        check("stray_rdata", {f_rdata, d_rdata}, 0);
        mem_ack = 0;
        tick();
        check("stray_mem_req", mem_req, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
